// File: rtl/count_arb_pkg.sv
// rtl/count_arb_pkg.sv - shared state encoding and default sizes for count_arbiter
package count_arb_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    RUN  = S_RUN,
    DONE = S_DONE
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector
// Returns the first set request searching upward from last+1, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last,
  output logic [IDXW-1:0] winner,
  output logic            valid
);

  always_comb begin
    int idx;
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    // Walk from the farthest candidate back to the nearest so the nearest set bit wins.
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (req[IDXW'(idx)]) begin
        winner = IDXW'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/count_arbiter.sv
// rtl/count_arbiter.sv - round-robin sharing of one up-counter between NREQ requesters
module count_arbiter
  import count_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDXW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  T,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] len,
  output logic [NREQ-1:0]       grant,
  output logic [IDXW-1:0]       owner,
  output logic                  busy,
  output logic [WIDTH-1:0]      count,
  output logic [NREQ-1:0]       done
);

  state_t           state;
  logic [IDXW-1:0]  last;
  logic [WIDTH-1:0] target;
  logic [IDXW-1:0]  winner;
  logic             win_valid;
  logic [WIDTH-1:0] len_arr [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      len_arr[i] = len[i*WIDTH +: WIDTH];
    end
  end

  rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
    .req    (req),
    .last   (last),
    .winner (winner),
    .valid  (win_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      owner  <= '0;
      last   <= IDXW'(NREQ - 1);
      count  <= '0;
      target <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            state  <= RUN;
            owner  <= winner;
            last   <= winner;
            count  <= '0;
            target <= len_arr[winner];
          end
        end
        RUN: begin
          // Abort outranks completion, even on the final trigger.
          if (!req[owner]) begin
            state <= IDLE;
          end else if (target == '0) begin
            state <= DONE;
          end else if (T) begin
            count <= count + WIDTH'(1);
            if (count == target - WIDTH'(1)) begin
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    grant = '0;
    done  = '0;
    if (state == RUN)  grant[owner] = 1'b1;
    if (state == DONE) done[owner]  = 1'b1;
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_count_arbiter.sv
// tb/tb_count_arbiter.sv - self-checking bench for count_arbiter
module tb_count_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDXW  = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  T;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] len;
  logic [NREQ-1:0]       grant;
  logic [IDXW-1:0]       owner;
  logic                  busy;
  logic [WIDTH-1:0]      count;
  logic [NREQ-1:0]       done;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: phase 0 = idle, 1 = counting for owner, 2 = completion cycle.
  int m_ph, m_owner, m_last, m_count, m_target;
  int order[$];

  count_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .T     (T),
    .req   (req),
    .len   (len),
    .grant (grant),
    .owner (owner),
    .busy  (busy),
    .count (count),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_len(input int i, input int v);
    len[i*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  task automatic model_update();
    bit found;
    int c;
    if (reset) begin
      m_ph = 0; m_owner = 0; m_last = NREQ - 1; m_count = 0; m_target = 0;
    end else if (m_ph == 0) begin
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        c = (m_last + 1 + i) % NREQ;
        if (!found && req[c]) begin
          found = 1'b1;
          m_ph = 1; m_owner = c; m_last = c; m_count = 0;
          m_target = int'(len[c*WIDTH +: WIDTH]);
        end
      end
    end else if (m_ph == 1) begin
      if (!req[m_owner])        m_ph = 0;
      else if (m_target == 0)   m_ph = 2;
      else if (T) begin
        m_count = m_count + 1;
        if (m_count == m_target) m_ph = 2;
      end
    end else begin
      m_ph = 0;
    end
  endtask

  task automatic check_all();
    logic [NREQ-1:0] eg, ed;
    eg = (m_ph == 1) ? NREQ'(1 << m_owner) : '0;
    ed = (m_ph == 2) ? NREQ'(1 << m_owner) : '0;
    chk("grant", 32'(grant), 32'(eg));
    chk("done", 32'(done), 32'(ed));
    chk("busy", 32'(busy), 32'(m_ph != 0));
    chk("count", 32'(count), m_count);
    chk("owner", 32'(owner), m_owner);
    chk("grant_onehot0", 32'($onehot0(grant)), 1);
    chk("done_onehot0", 32'($onehot0(done)), 1);
    chk("grant_and_done", 32'(|(grant & done)), 0);
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    m_ph = 0; m_owner = 0; m_last = NREQ - 1; m_count = 0; m_target = 0;
    reset = 1'b1; T = 1'b0; req = '0; len = '0;

    // Reset state
    tick();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_count", 32'(count), 0);
    reset = 1'b0;
    tick();

    // Single run of length 3 with T held high
    set_len(0, 3); req = 4'b0001; T = 1'b1;
    tick();
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_count0", 32'(count), 0);
    tick(); tick();
    chk("t1_count2", 32'(count), 2);
    tick();
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_count3", 32'(count), 3);
    req = '0;
    tick();
    chk("t1_idle_busy", 32'(busy), 0);
    chk("t1_idle_count", 32'(count), 3);

    // All requesters, length 1, rotation order
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < NREQ; i++) set_len(i, 1);
    req = 4'b1111;
    for (int n = 0; n < 15; n++) begin
      tick();
      for (int i = 0; i < NREQ; i++) if (grant[i]) order.push_back(i);
    end
    chk("t2_runs", order.size(), 5);
    for (int i = 0; i < 5; i++) if (i < order.size()) chk("t2_order", order[i], i % NREQ);
    req = '0; tick();

    // Gated trigger pattern on requester 1
    set_len(1, 5); req = 4'b0010; T = 1'b0;
    tick();
    chk("t3_grant", 32'(grant), 32'h2);
    T = 1'b1; tick();
    T = 1'b0; tick();
    chk("t3_hold", 32'(count), 1);
    T = 1'b0; tick();
    T = 1'b1; tick();
    T = 1'b1; tick();
    T = 1'b0; tick();
    T = 1'b1; tick();
    chk("t3_count4", 32'(count), 4);
    T = 1'b1; tick();
    chk("t3_done", 32'(done), 32'h2);
    chk("t3_count5", 32'(count), 5);
    req = '0; tick();

    // Zero length run
    set_len(2, 0); req = 4'b0100;
    tick();
    chk("t4_grant", 32'(grant), 32'h4);
    tick();
    chk("t4_done", 32'(done), 32'h4);
    chk("t4_count", 32'(count), 0);
    req = '0; tick();

    // Abort at count 4 with requester 1 pending
    set_len(0, 10); req = 4'b0011; T = 1'b1;
    tick();
    chk("t5_owner0", 32'(grant), 32'h1);
    repeat (4) tick();
    chk("t5_count4", 32'(count), 4);
    req = 4'b0010;
    tick();
    chk("t5_abort_grant", 32'(grant), 0);
    chk("t5_abort_done", 32'(done), 0);
    chk("t5_abort_busy", 32'(busy), 0);
    tick();
    chk("t5_next_grant", 32'(grant), 32'h2);
    req = '0; tick(); tick();

    // Reset mid-run
    req = 4'b0001;
    tick(); tick(); tick();
    chk("t6_count2", 32'(count), 2);
    reset = 1'b1;
    tick();
    chk("t6_grant", 32'(grant), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_count", 32'(count), 0);
    chk("t6_done", 32'(done), 0);
    reset = 1'b0; req = 4'b1001;
    tick();
    chk("t6_prio", 32'(grant), 32'h1);
    req = '0; tick(); tick();

    // Maximum length run
    set_len(0, 255); req = 4'b0001; T = 1'b1;
    tick();
    repeat (254) tick();
    chk("t7_count254", 32'(count), 254);
    chk("t7_still_grant", 32'(grant), 32'h1);
    tick();
    chk("t7_done", 32'(done), 32'h1);
    chk("t7_count255", 32'(count), 255);
    req = '0; tick();

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      T = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < NREQ; i++) set_len(i, $urandom_range(0, 6));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
